// File: rtl/core_fetch_pkg.sv
// Shared fetch types: instruction word, word-address pointer, NOP encoding and FSM states.
package core_fetch_pkg;

    localparam int WORD_W = 32;
    localparam int PTR_W  = 30;

    typedef logic [WORD_W-1:0] word;
    typedef logic [PTR_W-1:0]  ptr;

    localparam word NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2,
        HALT    = 2'd3
    } fetch_state;

endpackage

// File: rtl/core_fetch.sv
// Instruction-fetch bus master: single-outstanding reads, flush redirect, stale-read drop.
// Optional bus-error reporting and HALT state enabled by CORE_FETCH_BUSERR_EN.
module core_fetch
    import core_fetch_pkg::*;
#(
    parameter ptr RESET_PC = '0
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  ptr   target,
    input  logic fetch,
    output logic fetched,
    output word  fetch_data,
    output ptr   mem_addr,
    output logic mem_start,
    input  logic mem_ready,
`ifdef CORE_FETCH_BUSERR_EN
    input  logic mem_fault,
    output logic fault,
    output ptr   fault_pc,
`endif
    input  word  mem_data
);

    // state   | meaning
    // IDLE    | no read outstanding
    // WAIT    | read outstanding, data will be delivered
    // DISCARD | read outstanding after a flush, data will be dropped
    // HALT    | bus error seen, waiting for flush (buserr build only)
    fetch_state state, state_n;
    ptr         fetch_pc, fetch_pc_n;
    ptr         mem_addr_n;
    logic       mem_start_n;
    logic       fetched_n;
    word        fetch_data_n;
`ifdef CORE_FETCH_BUSERR_EN
    logic       fault_n;
    ptr         fault_pc_n;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            fetch_pc   <= RESET_PC;
            mem_addr   <= RESET_PC;
            mem_start  <= 1'b0;
            fetched    <= 1'b0;
            fetch_data <= NOP;
`ifdef CORE_FETCH_BUSERR_EN
            fault      <= 1'b0;
            fault_pc   <= RESET_PC;
`endif
        end else begin
            state      <= state_n;
            fetch_pc   <= fetch_pc_n;
            mem_addr   <= mem_addr_n;
            mem_start  <= mem_start_n;
            fetched    <= fetched_n;
            fetch_data <= fetch_data_n;
`ifdef CORE_FETCH_BUSERR_EN
            fault      <= fault_n;
            fault_pc   <= fault_pc_n;
`endif
        end
    end

    always_comb begin
        state_n      = state;
        fetch_pc_n   = fetch_pc;
        mem_addr_n   = mem_addr;
        mem_start_n  = mem_start;
        fetched_n    = 1'b0;
        fetch_data_n = fetch_data;
`ifdef CORE_FETCH_BUSERR_EN
        fault_n      = 1'b0;
        fault_pc_n   = fault_pc;
`endif
        case (state)
            IDLE: begin
                if (flush) begin
                    fetch_pc_n = target;
                end else if (fetch) begin
                    mem_addr_n  = fetch_pc;
                    mem_start_n = 1'b1;
                    state_n     = WAIT;
                end
            end
            WAIT: begin
                if (mem_ready && flush) begin
                    fetch_pc_n  = target;
                    mem_start_n = 1'b0;
                    state_n     = IDLE;
`ifdef CORE_FETCH_BUSERR_EN
                end else if (mem_ready && mem_fault) begin
                    // PC stays on the faulting word so the handler sees where it stopped
                    fetched_n    = 1'b1;
                    fetch_data_n = NOP;
                    fault_n      = 1'b1;
                    fault_pc_n   = mem_addr;
                    mem_start_n  = 1'b0;
                    state_n      = HALT;
`endif
                end else if (mem_ready) begin
                    fetched_n    = 1'b1;
                    fetch_data_n = mem_data;
                    fetch_pc_n   = fetch_pc + 1'b1;
                    if (fetch) begin
                        mem_addr_n = fetch_pc + 1'b1;
                    end else begin
                        mem_start_n = 1'b0;
                        state_n     = IDLE;
                    end
                end else if (flush) begin
                    // bus cannot abort: keep the request up and drop its data later
                    fetch_pc_n = target;
                    state_n    = DISCARD;
                end
            end
            DISCARD: begin
                if (flush) begin
                    fetch_pc_n = target;
                end
                if (mem_ready) begin
                    mem_start_n = 1'b0;
                    state_n     = IDLE;
                end
            end
            default: begin
`ifdef CORE_FETCH_BUSERR_EN
                if (flush) begin
                    fetch_pc_n = target;
                    state_n    = IDLE;
                end
`else
                state_n = IDLE;
`endif
            end
        endcase
    end

endmodule

// File: tb/tb_core_fetch.sv
// Directed self-checking bench for core_fetch; memory side driven by hand, one step per clock.
module tb_core_fetch;
    import core_fetch_pkg::*;

    logic clk = 1'b0;
    logic rst, flush, fetch, mem_ready;
    ptr   target;
    logic fetched, mem_start;
    word  fetch_data, mem_data;
    ptr   mem_addr;
`ifdef CORE_FETCH_BUSERR_EN
    logic mem_fault, fault;
    ptr   fault_pc;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // memory returns a word tagged with its own address
    assign mem_data = {16'hD00D, mem_addr[15:0]};

    core_fetch #(.RESET_PC('0)) dut (
        .clk(clk), .rst(rst), .flush(flush), .target(target), .fetch(fetch),
        .fetched(fetched), .fetch_data(fetch_data), .mem_addr(mem_addr),
        .mem_start(mem_start), .mem_ready(mem_ready),
`ifdef CORE_FETCH_BUSERR_EN
        .mem_fault(mem_fault), .fault(fault), .fault_pc(fault_pc),
`endif
        .mem_data(mem_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bus(input string tag, input logic st, input logic [31:0] addr, input logic fd);
        chk({tag, ".mem_start"}, {31'd0, mem_start}, {31'd0, st});
        chk({tag, ".mem_addr"}, {2'b00, mem_addr}, addr);
        chk({tag, ".fetched"}, {31'd0, fetched}, {31'd0, fd});
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; target = '0; fetch = 1'b1; mem_ready = 1'b1;
`ifdef CORE_FETCH_BUSERR_EN
        mem_fault = 1'b0;
`endif
        tick();
        chk_bus("reset", 1'b0, 32'h0, 1'b0);
        chk("reset.fetch_data", fetch_data, 32'h0000_0013);
        rst = 1'b0;

        // streaming at one word per cycle
        tick(); chk_bus("stream.c1", 1'b1, 32'h0, 1'b0);
        tick(); chk_bus("stream.c2", 1'b1, 32'h1, 1'b1);
        chk("stream.d0", fetch_data, 32'hD00D_0000);
        tick(); chk_bus("stream.c3", 1'b1, 32'h2, 1'b1);
        chk("stream.d1", fetch_data, 32'hD00D_0001);
        tick(); chk_bus("stream.c4", 1'b1, 32'h3, 1'b1);
        chk("stream.d2", fetch_data, 32'hD00D_0002);
        fetch = 1'b0;
        tick(); chk_bus("stream.stop", 1'b0, 32'h3, 1'b1);
        chk("stream.d3", fetch_data, 32'hD00D_0003);
        tick(); chk("stream.idle.fetched", {31'd0, fetched}, 32'd0);

        // slow memory: request held three cycles, one pulse
        mem_ready = 1'b0; fetch = 1'b1;
        tick(); chk_bus("slow.req", 1'b1, 32'h4, 1'b0);
        fetch = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); chk_bus("slow.hold", 1'b1, 32'h4, 1'b0);
        end
        mem_ready = 1'b1;
        tick(); chk_bus("slow.done", 1'b0, 32'h4, 1'b1);
        chk("slow.data", fetch_data, 32'hD00D_0004);
        mem_ready = 1'b0;
        tick(); chk("slow.single", {31'd0, fetched}, 32'd0);

        // flush while waiting: in-flight word dropped, restart at target
        fetch = 1'b1;
        tick(); chk_bus("fw.req", 1'b1, 32'h5, 1'b0);
        fetch = 1'b0; flush = 1'b1; target = 30'h40;
        tick(); chk_bus("fw.discard", 1'b1, 32'h5, 1'b0);
        flush = 1'b0;
        tick(); chk_bus("fw.hold", 1'b1, 32'h5, 1'b0);
        mem_ready = 1'b1;
        tick(); chk_bus("fw.drop", 1'b0, 32'h5, 1'b0);
        mem_ready = 1'b0; fetch = 1'b1;
        tick(); chk_bus("fw.redirect", 1'b1, 32'h40, 1'b0);

        // flush coinciding with mem_ready
        mem_ready = 1'b1; flush = 1'b1; target = 30'h80; fetch = 1'b0;
        tick(); chk_bus("fr.drop", 1'b0, 32'h40, 1'b0);
        flush = 1'b0; fetch = 1'b1; mem_ready = 1'b0;
        tick(); chk_bus("fr.redirect", 1'b1, 32'h80, 1'b0);

        // two words then pause, resume at next PC
        mem_ready = 1'b1;
        tick(); chk_bus("pr.w0", 1'b1, 32'h81, 1'b1);
        chk("pr.d0", fetch_data, 32'hD00D_0080);
        fetch = 1'b0;
        tick(); chk_bus("pr.w1", 1'b0, 32'h81, 1'b1);
        chk("pr.d1", fetch_data, 32'hD00D_0081);
        fetch = 1'b1; mem_ready = 1'b0;
        tick(); chk_bus("pr.resume", 1'b1, 32'h82, 1'b0);
        mem_ready = 1'b1; fetch = 1'b0;
        tick(); chk_bus("pr.w2", 1'b0, 32'h82, 1'b1);
        chk("pr.d2", fetch_data, 32'hD00D_0082);

        // reset in the middle of an outstanding read
        mem_ready = 1'b0; fetch = 1'b1;
        tick(); chk_bus("mr.req", 1'b1, 32'h83, 1'b0);
        rst = 1'b1;
        tick(); chk_bus("mr.reset", 1'b0, 32'h0, 1'b0);
        chk("mr.data", fetch_data, 32'h0000_0013);
        rst = 1'b0;
        tick(); chk_bus("mr.restart", 1'b1, 32'h0, 1'b0);

`ifdef CORE_FETCH_BUSERR_EN
        // bus error at address 5 halts fetching until flush
        rst = 1'b1; fetch = 1'b0;
        tick(); rst = 1'b0;
        flush = 1'b1; target = 30'h5;
        tick(); flush = 1'b0; fetch = 1'b1;
        tick(); chk_bus("be.req", 1'b1, 32'h5, 1'b0);
        mem_ready = 1'b1; mem_fault = 1'b1;
        tick(); chk_bus("be.fault", 1'b0, 32'h5, 1'b1);
        chk("be.nop", fetch_data, 32'h0000_0013);
        chk("be.fault_pulse", {31'd0, fault}, 32'd1);
        chk("be.fault_pc", {2'b00, fault_pc}, 32'h5);
        mem_fault = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); chk_bus("be.halt", 1'b0, 32'h5, 1'b0);
            chk("be.fault_clr", {31'd0, fault}, 32'd0);
        end
        flush = 1'b1; target = 30'h10;
        tick(); chk_bus("be.flush", 1'b0, 32'h5, 1'b0);
        flush = 1'b0; mem_ready = 1'b0;
        tick(); chk_bus("be.restart", 1'b1, 32'h10, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/core_fetch.md
# core_fetch

Instruction-fetch bus master directly upstream of `core_prefetch`. It keeps the sequential fetch PC, turns the prefetch buffer's `fetch` request into single-outstanding memory reads, and returns each instruction word as a one-cycle `fetched` pulse with `fetch_data`. On `flush` it redirects to `target` and drops any read still in flight, so no stale word ever reaches prefetch.

## Interface
- `RESET_PC`, default 0: fetch PC (`ptr`, word address) loaded on reset.
- `clk`  in  1  clock, all state updates on the rising edge.
- `rst`  in  1  reset; one clock; reset is synchronous and active-high.
- `flush`  in  1  redirect, same signal that drives prefetch `flush`.
- `target`  in  `ptr`  redirect PC, same value as prefetch `head`; sampled when `flush`=1.
- `fetch`  in  1  prefetch wants another word.
- `fetched`  out  1  one-cycle pulse: `fetch_data` is valid this cycle.
- `fetch_data`  out  `word`  returned instruction.
- `mem_addr`  out  `ptr`  read address, held stable while `mem_start`=1.
- `mem_start`  out  1  read request, held until `mem_ready`.
- `mem_ready`  in  1  request complete; `mem_data` is valid this cycle.
- `mem_data`  in  `word`  read data.
- `mem_fault`, `fault`, `fault_pc`: present only with `CORE_FETCH_BUSERR_EN` (see Configuration).

## Operation
- State register `state` ∈ {IDLE, WAIT, DISCARD} (plus HALT when configured), and `fetch_pc`.
- Reset: `state`=IDLE, `fetch_pc`=`RESET_PC`, `mem_start`=0, `mem_addr`=`RESET_PC`, `fetched`=0, `fetch_data`=`NOP`.
- IDLE:
  - `flush`: `fetch_pc`←`target`, stay in IDLE.
  - else if `fetch`: `mem_addr`←`fetch_pc`, `mem_start`←1, go to WAIT.
- WAIT, `mem_ready`=1 and `flush`=0:
  - `fetched`←1, `fetch_data`←`mem_data`, `fetch_pc`←`fetch_pc`+1.
  - If `fetch`=1, issue the next read back-to-back: `mem_addr`←`fetch_pc`+1, keep `mem_start`=1, stay in WAIT.
  - Else `mem_start`←0, go to IDLE.
- WAIT, `mem_ready`=1 and `flush`=1: data dropped, `fetched` stays 0, `fetch_pc`←`target`, `mem_start`←0, go to IDLE.
- WAIT, `mem_ready`=0 and `flush`=1: the bus cannot abort, so `mem_start` and `mem_addr` are held; `fetch_pc`←`target`; go to DISCARD.
- DISCARD:
  - `mem_ready`: drop data, `mem_start`←0, go to IDLE.
  - A further `flush` in DISCARD only reloads `fetch_pc`.
- `fetched` is 0 in every cycle not listed above.
- `fetch_pc` wraps modulo 2^width(`ptr`).
- `rst` overrides everything, including a read in flight; the memory side is reset by the same `rst`.

## Timing
- `fetch`=1 in IDLE at cycle N: `mem_start`=1 in N+1; `mem_ready` at N+1 gives `fetched`=1 in N+2.
- Sustained throughput is one word per cycle when `mem_ready` stays high.
- `fetched` and `fetch_data` are registered; no combinational path from `mem_*` inputs to outputs.
- The cycle after any `flush` edge always has `fetched`=0.
- A `fetched` pulse that coincides with `flush` is discarded by prefetch; no extra handling is needed here.

## Configuration
- Macro: `CORE_FETCH_BUSERR_EN`.
- Defined: adds `mem_fault` (in, 1), `fault` (out, 1, registered pulse) and `fault_pc` (out, `ptr`).
- On `mem_ready` & `mem_fault` & !`flush`:
  - `fetched`←1 and `fetch_data`←`NOP`.
  - `fault`←1 and `fault_pc`←`mem_addr`.
  - `fetch_pc` is not advanced; go to HALT.
- HALT issues no requests and leaves only on `flush`, taking the IDLE flush behaviour.
- Undefined: the ports and HALT state do not exist; bus errors are invisible.

## Structure
- Shared in `core/uarch.sv`:
  - `word`, `ptr`, `NOP`.
  - New `fetch_state` enum (IDLE, WAIT, DISCARD, HALT).
- Single module, no sub-module: the FSM and PC counter are too tightly coupled to split.

## Test plan
- Reset with `RESET_PC`=0 and `fetch` held 1, `mem_ready` always 1 → `mem_addr` 0,1,2,3 on consecutive cycles; `fetched` high from cycle 2 onward with data in order.
- `mem_ready` delayed 3 cycles → `mem_addr` and `mem_start` stable for all 3; exactly one `fetched` pulse.
- `flush` with `target`=0x40 while WAIT, `mem_ready` 2 cycles later → that data is never `fetched`; next `mem_addr`=0x40.
- `flush` in the same cycle as `mem_ready` → no `fetched`; next read at `target`.
- `fetch` deasserted after 2 words → IDLE, `mem_start`=0, `fetch_pc`=2; reasserting resumes at address 2.
- With `CORE_FETCH_BUSERR_EN`, fault at address 5 → `fetch_data`=`NOP`, `fault` pulse, `fault_pc`=5, no requests until `flush`.
